// File: rtl/fifo_pkg.sv
// Shared definitions for the opcode-driven FIFO and the controllers that drive it.
package fifo_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_READ    = 2'b01,
        OP_WRITE   = 2'b10,
        OP_INVALID = 2'b11
    } opcode_e;

    localparam logic DATA_VALID   = 1'b1;
    localparam logic DATA_INVALID = 1'b0;

    localparam logic FLAG_ASSERTED = 1'b1;
    localparam logic FLAG_CLEAR    = 1'b0;
    localparam int   FLAG_EMPTY_BIT = 0;
    localparam int   FLAG_FULL_BIT  = 1;

    // Ceiling log2, used for index and counter widths.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: lowest eligible index at or above ptr, wrapping.
module rr_priority_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  eligible,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                any_grant,
    output logic [ID_WIDTH-1:0] winner
);

    localparam logic [2*NUM_REQ-1:0] ONE = {{(2*NUM_REQ-1){1'b0}}, 1'b1};

    logic [2*NUM_REQ-1:0] doubled_s;
    logic [2*NUM_REQ-1:0] mask_s;
    logic [2*NUM_REQ-1:0] masked_s;

    // Lower copy is masked below ptr; the unmasked upper copy provides the wrap-around.
    always_comb begin
        doubled_s = {eligible, eligible};
        mask_s    = ~((ONE << ptr) - ONE);
        masked_s  = doubled_s & mask_s;
        any_grant = |eligible;
        winner    = '0;
        for (int i = 2*NUM_REQ - 1; i >= 0; i--) begin
            winner = masked_s[i] ? ID_WIDTH'(i % NUM_REQ) : winner;
        end
    end

endmodule

// File: rtl/fifo_access_arbiter.sv
// Round-robin controller sharing one opcode-driven FIFO among several requesters,
// with shadow occupancy tracking and an ID-tagged read-return pipeline.
module fifo_access_arbiter
    import fifo_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 4,
    parameter int OPCODE_WIDTH = 2,
    parameter int NUM_ENTRIES  = 4,
    parameter int ID_WIDTH     = log2(NUM_REQ),
    parameter int CNT_WIDTH    = log2(NUM_ENTRIES) + 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQ-1:0]                 req,
    input  logic [NUM_REQ*OPCODE_WIDTH-1:0]    req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
    output logic [NUM_REQ-1:0]                 grant,
    output logic [OPCODE_WIDTH+DATA_WIDTH-1:0] vector_out,
    input  logic [DATA_WIDTH-1:0]              fifo_data_in,
    output logic                               rd_valid,
    output logic [DATA_WIDTH-1:0]              rd_data,
    output logic [ID_WIDTH-1:0]                rd_id,
    output logic [CNT_WIDTH-1:0]               count
);

    localparam logic [OPCODE_WIDTH-1:0] OPC_NOP   = OPCODE_WIDTH'(OP_NOP);
    localparam logic [OPCODE_WIDTH-1:0] OPC_READ  = OPCODE_WIDTH'(OP_READ);
    localparam logic [OPCODE_WIDTH-1:0] OPC_WRITE = OPCODE_WIDTH'(OP_WRITE);
    localparam logic [CNT_WIDTH-1:0]    CNT_FULL  = CNT_WIDTH'(NUM_ENTRIES);
    localparam logic [DATA_WIDTH-1:0]   DATA_ZERO = {DATA_WIDTH{1'b0}};

    logic [OPCODE_WIDTH-1:0]              op_s [NUM_REQ];
    logic [DATA_WIDTH-1:0]                data_s [NUM_REQ];
    logic [NUM_REQ-1:0]                   eligible_s;
    logic                                 any_grant_s;
    logic [ID_WIDTH-1:0]                  winner_s;
    logic [NUM_REQ-1:0]                   grant_next_s;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0]   vector_next_s;
    logic [CNT_WIDTH-1:0]                 count_next_s;
    logic [ID_WIDTH-1:0]                  ptr_next_s;
    logic                                 rd_issue_s;

    logic [NUM_REQ-1:0]                   grant_r;
    logic [OPCODE_WIDTH+DATA_WIDTH-1:0]   vector_r;
    logic [CNT_WIDTH-1:0]                 count_r;
    logic [ID_WIDTH-1:0]                  ptr_r;
    logic                                 pipe0_valid_r;
    logic [ID_WIDTH-1:0]                  pipe0_id_r;
    logic                                 pipe1_valid_r;
    logic [ID_WIDTH-1:0]                  pipe1_id_r;
    logic                                 rd_valid_r;
    logic [DATA_WIDTH-1:0]                rd_data_r;
    logic [ID_WIDTH-1:0]                  rd_id_r;

    // Unpack requests and qualify them against the shadow count so the FIFO never overflows or underflows.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            op_s[i]       = req_op[i*OPCODE_WIDTH +: OPCODE_WIDTH];
            data_s[i]     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            eligible_s[i] = req[i] &&
                            (((op_s[i] == OPC_WRITE) && (count_r < CNT_FULL)) ||
                             ((op_s[i] == OPC_READ)  && (count_r != '0)));
        end
    end

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .eligible  (eligible_s),
        .ptr       (ptr_r),
        .any_grant (any_grant_s),
        .winner    (winner_s)
    );

    // Next grant, FIFO command, occupancy and pointer for the winning request.
    always_comb begin
        grant_next_s  = '0;
        vector_next_s = {OPC_NOP, DATA_ZERO};
        count_next_s  = count_r;
        ptr_next_s    = ptr_r;
        rd_issue_s    = 1'b0;
        if (any_grant_s) begin
            grant_next_s = NUM_REQ'(1) << winner_s;
            ptr_next_s   = (winner_s == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner_s + ID_WIDTH'(1);
            case (op_s[winner_s])
                OPC_WRITE: begin
                    vector_next_s = {OPC_WRITE, data_s[winner_s]};
                    count_next_s  = count_r + CNT_WIDTH'(1);
                end
                OPC_READ: begin
                    vector_next_s = {OPC_READ, DATA_ZERO};
                    count_next_s  = count_r - CNT_WIDTH'(1);
                    rd_issue_s    = DATA_VALID;
                end
                default: begin
                    vector_next_s = {OPC_NOP, DATA_ZERO};
                    count_next_s  = count_r;
                end
            endcase
        end else begin
            grant_next_s = '0;
            ptr_next_s   = ptr_r;
        end
    end

    // State and output registers; the two-stage pipeline lines the ID up with FIFO read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r       <= '0;
            vector_r      <= {OPC_NOP, DATA_ZERO};
            count_r       <= '0;
            ptr_r         <= '0;
            pipe0_valid_r <= DATA_INVALID;
            pipe0_id_r    <= '0;
            pipe1_valid_r <= DATA_INVALID;
            pipe1_id_r    <= '0;
            rd_valid_r    <= 1'b0;
            rd_data_r     <= DATA_ZERO;
            rd_id_r       <= '0;
        end else begin
            grant_r       <= grant_next_s;
            vector_r      <= vector_next_s;
            count_r       <= count_next_s;
            ptr_r         <= ptr_next_s;
            pipe0_valid_r <= rd_issue_s;
            pipe0_id_r    <= winner_s;
            pipe1_valid_r <= pipe0_valid_r;
            pipe1_id_r    <= pipe0_id_r;
            rd_valid_r    <= pipe1_valid_r;
            if (pipe1_valid_r) begin
                rd_data_r <= fifo_data_in;
                rd_id_r   <= pipe1_id_r;
            end else begin
                rd_data_r <= rd_data_r;
                rd_id_r   <= rd_id_r;
            end
        end
    end

    assign grant      = grant_r;
    assign vector_out = vector_r;
    assign count      = count_r;
    assign rd_valid   = rd_valid_r;
    assign rd_data    = rd_data_r;
    assign rd_id      = rd_id_r;

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Directed bench for fifo_access_arbiter driving a small behavioural opcode FIFO.
module tb_fifo_access_arbiter;
    import fifo_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_op;
    logic [15:0] req_data;
    logic [3:0]  grant;
    logic [5:0]  vector_out;
    logic [3:0]  fifo_data_in;
    logic        rd_valid;
    logic [3:0]  rd_data;
    logic [1:0]  rd_id;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fifo_access_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_op       (req_op),
        .req_data     (req_data),
        .grant        (grant),
        .vector_out   (vector_out),
        .fifo_data_in (fifo_data_in),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_id        (rd_id),
        .count        (count)
    );

    // Behavioural depth-4 FIFO executing the registered command
    logic [3:0] fmem [4];
    logic [1:0] fwp;
    logic [1:0] frp;
    logic [3:0] fifo_q;

    always @(posedge clk) begin
        if (reset) begin
            fwp    <= 2'd0;
            frp    <= 2'd0;
            fifo_q <= 4'h0;
        end else begin
            case (vector_out[5:4])
                2'b10: begin
                    fmem[fwp] <= vector_out[3:0];
                    fwp       <= fwp + 2'd1;
                end
                2'b01: begin
                    fifo_q <= fmem[frp];
                    frp    <= frp + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign fifo_data_in = fifo_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] d);
        req[i]            = 1'b1;
        req_op[i*2 +: 2]  = op;
        req_data[i*4 +: 4] = d;
    endtask

    task automatic drop(input int i);
        req[i]           = 1'b0;
        req_op[i*2 +: 2] = 2'b00;
    endtask

    task automatic clear_and_reset();
        req      = 4'b0000;
        req_op   = 8'h00;
        req_data = 16'h0000;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_g;

        // Reset values
        req      = 4'b0000;
        req_op   = 8'h00;
        req_data = 16'h0000;
        reset    = 1'b1;
        tick();
        tick();
        chk("rst_grant", grant, 4'b0000);
        chk("rst_vector", vector_out, 6'b00_0000);
        chk("rst_count", count, 3'd0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 4'h0);
        chk("rst_rd_id", rd_id, 2'd0);
        reset = 1'b0;

        // Write then read
        set_req(0, OP_WRITE, 4'hA);
        tick();
        chk("wr_grant", grant, 4'b0001);
        chk("wr_vector", vector_out, 6'b10_1010);
        chk("wr_count", count, 3'd1);
        drop(0);
        set_req(2, OP_READ, 4'h0);
        tick();
        chk("rd_grant", grant, 4'b0100);
        chk("rd_vector", vector_out, 6'b01_0000);
        chk("rd_count", count, 3'd0);
        drop(2);
        tick();
        chk("idle_grant", grant, 4'b0000);
        chk("idle_vector", vector_out, 6'b00_0000);
        chk("rd_early", rd_valid, 1'b0);
        tick();
        chk("ret_valid", rd_valid, 1'b1);
        chk("ret_data", rd_data, 4'hA);
        chk("ret_id", rd_id, 2'd2);
        tick();
        chk("ret_one_wide", rd_valid, 1'b0);

        // Round-robin fairness
        clear_and_reset();
        for (int i = 0; i < 4; i++) set_req(i, OP_WRITE, 4'(5 + i));
        for (int k = 0; k < 4; k++) begin
            tick();
            exp_g = 4'b0001 << k;
            chk("rr_wr_grant", grant, exp_g);
            chk("rr_wr_count", count, k + 1);
            drop(k);
        end
        for (int i = 0; i < 4; i++) set_req(i, OP_READ, 4'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k < 4) begin
                exp_g = 4'b0001 << k;
                chk("rr_rd_grant", grant, exp_g);
                chk("rr_rd_count", count, 3 - k);
                drop(k);
            end else begin
                chk("rr_rd_nogrant", grant, 4'b0000);
            end
            if (k >= 2) begin
                chk("rr_ret_valid", rd_valid, 1'b1);
                chk("rr_ret_data", rd_data, 5 + k - 2);
                chk("rr_ret_id", rd_id, k - 2);
            end else begin
                chk("rr_ret_quiet", rd_valid, 1'b0);
            end
        end

        // Full boundary
        for (int k = 0; k < 4; k++) begin
            set_req(0, OP_WRITE, 4'(k + 1));
            tick();
            chk("fill_grant", grant, 4'b0001);
            chk("fill_count", count, k + 1);
        end
        drop(0);
        set_req(1, OP_WRITE, 4'hF);
        set_req(3, OP_READ, 4'h0);
        tick();
        chk("full_grant", grant, 4'b1000);
        chk("full_vector", vector_out, 6'b01_0000);
        chk("full_count", count, 3'd3);
        drop(3);
        tick();
        chk("full_wr_grant", grant, 4'b0010);
        chk("full_wr_vector", vector_out, 6'b10_1111);
        chk("full_wr_count", count, 3'd4);
        drop(1);
        tick();
        chk("full_ret_valid", rd_valid, 1'b1);
        chk("full_ret_data", rd_data, 4'h1);
        chk("full_ret_id", rd_id, 2'd3);

        // Empty boundary
        clear_and_reset();
        for (int i = 0; i < 4; i++) set_req(i, OP_READ, 4'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("empty_grant", grant, 4'b0000);
            chk("empty_vector", vector_out, 6'b00_0000);
            chk("empty_count", count, 3'd0);
        end
        set_req(2, OP_WRITE, 4'hC);
        tick();
        chk("empty_wr_grant", grant, 4'b0100);
        chk("empty_wr_vector", vector_out, 6'b10_1100);
        chk("empty_wr_count", count, 3'd1);
        drop(2);
        tick();
        chk("empty_rd_grant", grant, 4'b1000);
        chk("empty_rd_vector", vector_out, 6'b01_0000);
        chk("empty_rd_count", count, 3'd0);
        req    = 4'b0000;
        req_op = 8'h00;
        tick();
        chk("empty_after_grant", grant, 4'b0000);
        tick();
        chk("empty_ret_valid", rd_valid, 1'b1);
        chk("empty_ret_data", rd_data, 4'hC);
        chk("empty_ret_id", rd_id, 2'd3);

        // Wrap-around with alternating write/read pairs
        clear_and_reset();
        for (int v = 0; v < 10; v++) begin
            set_req(0, OP_WRITE, 4'(v));
            tick();
            chk("wrap_wr_grant", grant, 4'b0001);
            chk("wrap_wr_count", count, 3'd1);
            chk("wrap_wr_quiet", rd_valid, 1'b0);
            drop(0);
            set_req(1, OP_READ, 4'h0);
            tick();
            chk("wrap_rd_grant", grant, 4'b0010);
            chk("wrap_rd_count", count, 3'd0);
            if (v > 0) begin
                chk("wrap_ret_valid", rd_valid, 1'b1);
                chk("wrap_ret_data", rd_data, v - 1);
                chk("wrap_ret_id", rd_id, 2'd1);
            end
            drop(1);
        end
        tick();
        chk("wrap_tail_quiet", rd_valid, 1'b0);
        tick();
        chk("wrap_last_valid", rd_valid, 1'b1);
        chk("wrap_last_data", rd_data, 4'h9);

        // Reset while a read is in flight
        clear_and_reset();
        set_req(0, OP_WRITE, 4'h6);
        tick();
        drop(0);
        set_req(1, OP_READ, 4'h0);
        tick();
        chk("mid_rd_grant", grant, 4'b0010);
        drop(1);
        reset = 1'b1;
        tick();
        chk("mid_grant", grant, 4'b0000);
        chk("mid_vector", vector_out, 6'b00_0000);
        chk("mid_count", count, 3'd0);
        chk("mid_rd_valid", rd_valid, 1'b0);
        chk("mid_rd_data", rd_data, 4'h0);
        chk("mid_rd_id", rd_id, 2'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mid_no_return", rd_valid, 1'b0);
            chk("mid_count_hold", count, 3'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Round-robin controller that shares one opcode-driven FIFO (`fifo_top`) between `NUM_REQ` requesters. Each cycle it picks at most one legal request and drives the FIFO command vector `{opcode, data}`. It keeps a shadow occupancy count so full/empty decisions never depend on FIFO flag timing. It captures read data from the FIFO and returns it, tagged with the requester ID.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `DATA_WIDTH`, 4, FIFO data width
- `OPCODE_WIDTH`, 2, command opcode width
- `NUM_ENTRIES`, 4, FIFO depth; power of two, 2..256
- `ID_WIDTH`, `LOG2(NUM_REQ)`, requester ID width
- `CNT_WIDTH`, `LOG2(NUM_ENTRIES)+1`, occupancy counter width

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high; the same signal also resets the FIFO
- `req`  in  NUM_REQ  per-requester request, level
- `req_op`  in  NUM_REQ*OPCODE_WIDTH  per-requester opcode; slice i is `[i*OPCODE_WIDTH +: OPCODE_WIDTH]`
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-requester write data
- `grant`  out  NUM_REQ  one-hot (or zero), registered
- `vector_out`  out  OPCODE_WIDTH+DATA_WIDTH  command to the FIFO's `vector_in`; `{opcode, data}`
- `fifo_data_in`  in  DATA_WIDTH  the FIFO's `data_out`
- `rd_valid`  out  1  read data return strobe
- `rd_data`  out  DATA_WIDTH  returned read data
- `rd_id`  out  ID_WIDTH  requester the read data belongs to
- `count`  out  CNT_WIDTH  shadow occupancy, 0..NUM_ENTRIES

## Operation
- **Opcodes:** READ=2'b01, WRITE=2'b10, NOP=2'b00, INVALID=2'b11.
- **Eligibility:**
  - Requester i is eligible when `req[i]` is high and either its op is WRITE with `count < NUM_ENTRIES`, or its op is READ with `count > 0`.
  - NOP and INVALID ops are never eligible.
  - An ineligible request stays pending. It is not rejected and receives no grant.
- **Arbitration:**
  - Round-robin pointer `ptr`. Priority order is ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - On a grant to requester w, `ptr` becomes (w+1) mod NUM_REQ.
  - With no grant, `ptr` holds.
- **On a grant to w**, registered at the edge:
  - `grant` becomes one-hot(w).
  - For WRITE, `vector_out` becomes `{WRITE, req_data[w]}` and `count` increments by 1.
  - For READ, `vector_out` becomes `{READ, 0}` and `count` decrements by 1.
  - For READ, the ID w enters the return pipeline.
- **No grant:** `grant` = 0 and `vector_out` = `{NOP, 0}`.
- **Requester handshake:** a requester must drop or change its request in the cycle after seeing its grant. A request held unchanged is treated as a new operation.
- **Legality:** the shadow count guarantees the FIFO never receives a WRITE when full or a READ when empty. The FIFO's flags and its X output on an invalid read are therefore never exercised.
- **Counter rules:** exactly one operation per cycle, so `count` changes by at most ±1 and never wraps.

## Timing
- **Reset values:**
  - Outputs: `grant` = 0, `vector_out` = `{NOP, 0}`, `count` = 0, `rd_valid` = 0, `rd_data` = 0, `rd_id` = 0.
  - Internal: `ptr` = 0, return pipeline cleared.
- **Cycle C:** `grant` / `vector_out` are valid, registered at the edge from the requests sampled in C-1. Request-to-grant latency is 1 cycle.
- **FIFO:** executes the command at the edge ending C, so `fifo_data_in` is stable during C+1.
- **Read return:** at the edge ending C+1, the controller registers `rd_data` ← `fifo_data_in` and `rd_id` ← the granted ID, and asserts `rd_valid` for C+2, one cycle wide.
  - Read-grant-to-data latency: 2 cycles. Request-to-data latency: 3 cycles.
- **Throughput:** back-to-back reads return on consecutive cycles. The return pipeline is 2 deep, tagged with valid bit + ID.
- **Simultaneous events:**
  - With `count` = NUM_ENTRIES, a WRITE and a READ requested together: only the READ is eligible.
  - With `count` = 0: only the WRITE is eligible.
- **Reset mid-operation:** in-flight reads are discarded (no `rd_valid`), and `count` returns to 0 consistent with the FIFO's own reset.

## Structure
- **Shared package `fifo_pkg`:**
  - opcode constants READ/WRITE/NOP/INVALID
  - DATA_VALID/INVALID and FIFO flag constants
  - the `LOG2` function/macro used for `ID_WIDTH` and `CNT_WIDTH`
  - `fifo_top` uses the same package.
- **Sub-module `rr_priority_pick`:**
  - combinational; inputs: eligible vector and `ptr`
  - outputs: `any_grant` and the winner index
  - implemented as a double-width masked priority encoder.
- The controller itself holds `ptr`, `count`, the output registers and the return pipeline.

## Test plan
- **Write then read:** Reset; requester 0 issues WRITE 4'hA.
  - `grant` = 4'b0001 and `vector_out` = 6'b10_1010 one cycle later; `count` = 1.
  - Requester 2 then issues READ → `rd_valid` with `rd_data` = 4'hA and `rd_id` = 2, 2 cycles after its grant; `count` = 0.
- **Round-robin fairness:** all 4 requesters hold WRITE with `count` = 0 → grants in order 0, 1, 2, 3, with `count` 1..4. All 4 then switch to READ → grants 0, 1, 2, 3 and data returned in FIFO order.
- **Full boundary:** with `count` = 4, requester 1 WRITE and requester 3 READ requested together → only 3 is granted. Requester 1 is granted the following cycle, and `count` returns to 4.
- **Empty boundary:** with `count` = 0, READ from all requesters → no grant and `vector_out` stays NOP indefinitely. A WRITE arriving is granted immediately.
- **Wrap-around:** 10 alternating WRITE/READ pairs with values 0..9 → every read returns the matching value, `count` oscillates 0/1, and FIFO pointers wrap twice.
- **Reset mid-flight:** assert `reset` one cycle after a READ grant → `rd_valid` never asserts and all outputs return to their reset values the next cycle.
